// File: rtl/stream_distributor_flushable_pkg.sv
// Shared types and index arithmetic for the flushable round-robin stream distributor.
package stream_distributor_flushable_pkg;

  typedef enum logic {
    LZC_TRAILING = 1'b0,
    LZC_LEADING  = 1'b1
  } lzc_mode_e;

  // Successor of an output index; explicit compare so non-power-of-two counts wrap correctly.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

  // (a + b) mod n for operands already below n.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned sum;
    sum = a + b;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/stream_distributor_flushable_lzc.sv
// Leading/trailing zero counter; empty_o flags an all-zero input.
module stream_distributor_flushable_lzc
  import stream_distributor_flushable_pkg::*;
#(
  parameter int unsigned WIDTH    = 2,
  parameter lzc_mode_e   MODE     = LZC_TRAILING,
  localparam int unsigned CntWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]    in_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                empty_o
);

  always_comb begin
    int k;
    k     = 0;
    cnt_o = '0;
    // Descending scan so the smallest qualifying count is the one that sticks.
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      k = (MODE == LZC_TRAILING) ? i : int'(WIDTH) - 1 - i;
      if (in_i[k]) cnt_o = CntWidth'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/stream_distributor_flushable.sv
// One-entry buffered 1-to-N stream distributor with round-robin destination choice and flush.
module stream_distributor_flushable
  import stream_distributor_flushable_pkg::*;
#(
  parameter type         DATA_T   = logic,
  parameter int          N_OUP    = -1,
  parameter int unsigned IdxWidth = (N_OUP > 1) ? $clog2(N_OUP) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  DATA_T                 inp_data_i,
  input  logic                  inp_valid_i,
  output logic                  inp_ready_o,
  output DATA_T [N_OUP-1:0]     oup_data_o,
  output logic  [N_OUP-1:0]     oup_valid_o,
  input  logic  [N_OUP-1:0]     oup_ready_i,
  output logic  [IdxWidth-1:0]  idx_o
);

  typedef logic [IdxWidth-1:0] idx_t;

  localparam int unsigned NOup = (N_OUP > 0) ? N_OUP : 1;

  if (N_OUP < 1) begin : g_n_oup_check
    $fatal(1, "stream_distributor_flushable: N_OUP must be at least 1");
  end

  logic             full_q;
  DATA_T            data_q;
  idx_t             idx_q;
  idx_t             rr_q;

  logic             oup_hs;
  logic             inp_hs;
  idx_t             rr_eff;
  idx_t             sel;
  logic [N_OUP-1:0] ready_rot;
  idx_t             tz_cnt;
  logic             tz_empty;

  // Outputs come straight from state so valid never waits on a ready.
  always_comb begin
    oup_valid_o = '0;
    oup_data_o  = '0;
    for (int i = 0; i < N_OUP; i++) begin
      oup_valid_o[i] = full_q & (idx_q == idx_t'(i));
      oup_data_o[i]  = data_q;
    end
  end

  assign idx_o       = idx_q;
  assign oup_hs      = |(oup_valid_o & oup_ready_i);
  assign inp_ready_o = ~flush_i & (~full_q | oup_hs);
  assign inp_hs      = inp_valid_i & inp_ready_o;

  // A beat leaving this cycle advances the pointer before the new beat is placed.
  assign rr_eff = oup_hs ? idx_t'(rr_next(32'(idx_q), NOup)) : rr_q;

  always_comb begin
    ready_rot = '0;
    for (int unsigned j = 0; j < NOup; j++) begin
      ready_rot[j] = oup_ready_i[wrap_add(j, 32'(rr_eff), NOup)];
    end
  end

  stream_distributor_flushable_lzc #(
    .WIDTH (NOup),
    .MODE  (LZC_TRAILING)
  ) u_lzc (
    .in_i    (ready_rot),
    .cnt_o   (tz_cnt),
    .empty_o (tz_empty)
  );

  assign sel = tz_empty ? rr_eff : idx_t'(wrap_add(32'(tz_cnt), 32'(rr_eff), NOup));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
      idx_q  <= '0;
      rr_q   <= '0;
    end else if (flush_i) begin
      full_q <= 1'b0;
      rr_q   <= '0;
    end else begin
      if (oup_hs) rr_q <= rr_eff;
      if (inp_hs) begin
        full_q <= 1'b1;
        data_q <= inp_data_i;
        idx_q  <= sel;
      end else if (oup_hs) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_distributor_flushable.sv
// Directed bench for the round-robin distributor at N_OUP = 3, 4 and 1.
module tb_stream_distributor_flushable;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N_OUP = 3
  logic            d3_flush, d3_v, d3_ir;
  logic [7:0]      d3_d;
  logic [2:0][7:0] d3_od;
  logic [2:0]      d3_ov, d3_rdy;
  logic [1:0]      d3_idx;
  // N_OUP = 4
  logic            d4_flush, d4_v, d4_ir;
  logic [7:0]      d4_d;
  logic [3:0][7:0] d4_od;
  logic [3:0]      d4_ov, d4_rdy;
  logic [1:0]      d4_idx;
  // N_OUP = 1
  logic            d1_flush, d1_v, d1_ir;
  logic [7:0]      d1_d;
  logic [0:0][7:0] d1_od;
  logic [0:0]      d1_ov, d1_rdy;
  logic [0:0]      d1_idx;

  stream_distributor_flushable #(.DATA_T(logic [7:0]), .N_OUP(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(d3_flush), .inp_data_i(d3_d), .inp_valid_i(d3_v),
    .inp_ready_o(d3_ir), .oup_data_o(d3_od), .oup_valid_o(d3_ov), .oup_ready_i(d3_rdy),
    .idx_o(d3_idx));

  stream_distributor_flushable #(.DATA_T(logic [7:0]), .N_OUP(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(d4_flush), .inp_data_i(d4_d), .inp_valid_i(d4_v),
    .inp_ready_o(d4_ir), .oup_data_o(d4_od), .oup_valid_o(d4_ov), .oup_ready_i(d4_rdy),
    .idx_o(d4_idx));

  stream_distributor_flushable #(.DATA_T(logic [7:0]), .N_OUP(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(d1_flush), .inp_data_i(d1_d), .inp_valid_i(d1_v),
    .inp_ready_o(d1_ir), .oup_data_o(d1_od), .oup_valid_o(d1_ov), .oup_ready_i(d1_rdy),
    .idx_o(d1_idx));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [2:0] rdy;
    logic       fl;
    logic       e_ir;
    logic [2:0] e_v;
    logic [7:0] e_d;
    logic [1:0] e_idx;
  } vec_t;

  vec_t tbl[20];

  // Expected values describe the cycle in which the inputs are applied (state before the edge).
  task automatic cyc4(input string nm, input logic v, input logic [7:0] d, input logic [3:0] rdy,
                      input logic e_ir, input logic [3:0] e_v, input logic [7:0] e_d,
                      input logic [1:0] e_idx);
    @(negedge clk);
    d4_v = v; d4_d = d; d4_rdy = rdy;
    #1;
    chk({nm, "_ready"}, 32'(d4_ir), 32'(e_ir));
    chk({nm, "_valid"}, 32'(d4_ov), 32'(e_v));
    if (e_v != 4'b0000) begin
      chk({nm, "_data"}, 32'(d4_od[e_idx]), 32'(e_d));
      chk({nm, "_idx"},  32'(d4_idx), 32'(e_idx));
    end
  endtask

  initial begin
    byte unsigned q[$];
    logic exp_ir;
    int   sent, recv;

    tbl[0]  = '{1'b1, 8'hA1, 3'b111, 1'b0, 1'b1, 3'b000, 8'h00, 2'd0};
    tbl[1]  = '{1'b1, 8'hB2, 3'b111, 1'b0, 1'b1, 3'b001, 8'hA1, 2'd0};
    tbl[2]  = '{1'b1, 8'hC3, 3'b111, 1'b0, 1'b1, 3'b010, 8'hB2, 2'd1};
    tbl[3]  = '{1'b1, 8'hD4, 3'b111, 1'b0, 1'b1, 3'b100, 8'hC3, 2'd2};
    tbl[4]  = '{1'b0, 8'h00, 3'b111, 1'b0, 1'b1, 3'b001, 8'hD4, 2'd0};
    tbl[5]  = '{1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 3'b000, 8'hD4, 2'd0};
    tbl[6]  = '{1'b1, 8'h5A, 3'b100, 1'b0, 1'b1, 3'b000, 8'hD4, 2'd0};
    tbl[7]  = '{1'b1, 8'h77, 3'b011, 1'b0, 1'b0, 3'b100, 8'h5A, 2'd2};
    tbl[8]  = '{1'b1, 8'h77, 3'b001, 1'b0, 1'b0, 3'b100, 8'h5A, 2'd2};
    tbl[9]  = '{1'b1, 8'h77, 3'b010, 1'b0, 1'b0, 3'b100, 8'h5A, 2'd2};
    tbl[10] = '{1'b1, 8'h77, 3'b011, 1'b0, 1'b0, 3'b100, 8'h5A, 2'd2};
    tbl[11] = '{1'b1, 8'h77, 3'b000, 1'b0, 1'b0, 3'b100, 8'h5A, 2'd2};
    tbl[12] = '{1'b1, 8'h66, 3'b100, 1'b0, 1'b1, 3'b100, 8'h5A, 2'd2};
    tbl[13] = '{1'b0, 8'h00, 3'b100, 1'b0, 1'b1, 3'b100, 8'h66, 2'd2};
    tbl[14] = '{1'b1, 8'h11, 3'b010, 1'b0, 1'b1, 3'b000, 8'h66, 2'd2};
    tbl[15] = '{1'b0, 8'h00, 3'b010, 1'b0, 1'b1, 3'b010, 8'h11, 2'd1};
    tbl[16] = '{1'b1, 8'h33, 3'b000, 1'b0, 1'b1, 3'b000, 8'h11, 2'd1};
    tbl[17] = '{1'b1, 8'h99, 3'b000, 1'b1, 1'b0, 3'b100, 8'h33, 2'd2};
    tbl[18] = '{1'b1, 8'h44, 3'b110, 1'b0, 1'b1, 3'b000, 8'h33, 2'd2};
    tbl[19] = '{1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 3'b010, 8'h44, 2'd1};

    d3_flush = 0; d3_v = 0; d3_d = '0; d3_rdy = '0;
    d4_flush = 0; d4_v = 0; d4_d = '0; d4_rdy = '0;
    d1_flush = 0; d1_v = 0; d1_d = '0; d1_rdy = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst3_valid", 32'(d3_ov), 32'd0);
    chk("rst3_idx",   32'(d3_idx), 32'd0);
    chk("rst3_data",  32'(d3_od), 32'd0);
    chk("rst3_ready", 32'(d3_ir), 32'd1);
    chk("rst4_valid", 32'(d4_ov), 32'd0);
    chk("rst1_valid", 32'(d1_ov), 32'd0);

    // Round-robin, backpressure and flush on the 3-output instance.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      d3_v = tbl[i].v; d3_d = tbl[i].d; d3_rdy = tbl[i].rdy; d3_flush = tbl[i].fl;
      #1;
      chk($sformatf("r%0d_ready", i), 32'(d3_ir), 32'(tbl[i].e_ir));
      chk($sformatf("r%0d_valid", i), 32'(d3_ov), 32'(tbl[i].e_v));
      for (int k = 0; k < 3; k++)
        chk($sformatf("r%0d_data%0d", i, k), 32'(d3_od[k]), 32'(tbl[i].e_d));
      chk($sformatf("r%0d_idx", i), 32'(d3_idx), 32'(tbl[i].e_idx));
    end
    @(negedge clk);
    d3_v = 0; d3_rdy = '0; d3_flush = 0;

    // Skip non-ready outputs with the pointer at 1, then check the wrap to 0.
    cyc4("s0", 1'b1, 8'h10, 4'b0001, 1'b1, 4'b0000, 8'h00, 2'd0);
    cyc4("s1", 1'b0, 8'h00, 4'b0001, 1'b1, 4'b0001, 8'h10, 2'd0);
    cyc4("s2", 1'b1, 8'h20, 4'b1001, 1'b1, 4'b0000, 8'h00, 2'd0);
    cyc4("s3", 1'b0, 8'h00, 4'b0000, 1'b0, 4'b1000, 8'h20, 2'd3);
    cyc4("s4", 1'b0, 8'h00, 4'b1000, 1'b1, 4'b1000, 8'h20, 2'd3);
    cyc4("s5", 1'b1, 8'h30, 4'b1011, 1'b1, 4'b0000, 8'h00, 2'd0);
    cyc4("s6", 1'b0, 8'h00, 4'b0000, 1'b0, 4'b0001, 8'h30, 2'd0);

    // Single output: random valid/ready against an in-order queue model.
    sent = 0; recv = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      d1_v   = (c >= 56) ? 1'b0 : 1'($urandom_range(0, 1));
      d1_d   = 8'($urandom);
      d1_rdy = (c >= 56) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      exp_ir = (q.size() == 0) || d1_rdy[0];
      chk($sformatf("n1_c%0d_valid", c), 32'(d1_ov), 32'(q.size() != 0));
      chk($sformatf("n1_c%0d_ready", c), 32'(d1_ir), 32'(exp_ir));
      chk($sformatf("n1_c%0d_idx", c), 32'(d1_idx), 32'd0);
      if (q.size() != 0) begin
        chk($sformatf("n1_c%0d_data", c), 32'(d1_od[0]), 32'(q[0]));
        if (d1_rdy[0]) begin
          void'(q.pop_front());
          recv++;
        end
      end
      if (d1_v && exp_ir) begin
        q.push_back(d1_d);
        sent++;
      end
    end
    chk("n1_lossless", 32'(recv), 32'(sent));
    @(negedge clk);
    d1_v = 0; d1_rdy = '0;

    // Asynchronous reset while beats are held.
    #1;
    chk("pre_rst3_valid", 32'(d3_ov), 32'(3'b010));
    chk("pre_rst4_valid", 32'(d4_ov), 32'(4'b0001));
    #1;
    rst = 1'b1;
    #1;
    chk("arst3_valid", 32'(d3_ov), 32'd0);
    chk("arst4_valid", 32'(d4_ov), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post3_idx",   32'(d3_idx), 32'd0);
    chk("post3_data",  32'(d3_od), 32'd0);
    chk("post3_ready", 32'(d3_ir), 32'd1);
    chk("post4_idx",   32'(d4_idx), 32'd0);
    chk("post4_data",  32'(d4_od), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_distributor_flushable.md
# stream_distributor_flushable

Distributes one valid/ready input stream across `N_OUP` output streams with round-robin destination selection, as the counterpart of the flushable N-to-1 stream arbiter. Each beat is captured into a one-entry buffer, bound to exactly one output, and held there until that output handshakes. A synchronous flush drops the buffered beat and restarts the round-robin pointer. The block sits in front of replicated workers or banks that consume a shared stream.

## Interface
- `DATA_T`, `logic`: payload type.
- `N_OUP`, `-1`: number of outputs. Must be ≥ 1; an elaboration assertion enforces this.
- `IdxWidth`, `(N_OUP > 1) ? $clog2(N_OUP) : 1`: derived; width of index signals. Do not override.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `flush_i` in 1: synchronous flush.
- `inp_data_i` in `DATA_T`: input payload.
- `inp_valid_i` in 1: input valid.
- `inp_ready_o` out 1: input ready.
- `oup_data_o` out `DATA_T [N_OUP-1:0]`: per-output payload. All lanes carry the buffered data.
- `oup_valid_o` out `[N_OUP-1:0]`: one-hot or zero.
- `oup_ready_i` in `[N_OUP-1:0]`: per-output ready.
- `idx_o` out `IdxWidth`: index of the output holding the current beat. Valid only while `|oup_valid_o`.

## Operation

**State:**
- `full_q`: buffer occupied.
- `data_q`: buffered payload.
- `idx_q`: bound destination.
- `rr_q`: next preferred output.

**Outputs:**
- `oup_valid_o[i] = full_q & (idx_q == i)`.
- `oup_data_o[i] = data_q` for every `i`.
- `idx_o = idx_q`.
- `oup_valid_o` is a pure register output and never depends on any ready signal.

**Handshakes:**
- Output handshake `oup_hs = full_q & oup_ready_i[idx_q]`.
- `inp_ready_o = ~flush_i & (~full_q | oup_hs)`.
- Input handshake `inp_hs = inp_valid_i & inp_ready_o`.

**Destination selection on `inp_hs`:**
- Pick the first `i` at or after `rr_q`, wrapping modulo `N_OUP`, with `oup_ready_i[i]` high in the capture cycle.
- If no output is ready, pick `rr_q`.
- The chosen index is latched into `idx_q` and stays fixed until `oup_hs`. The beat never migrates to another output, even if its destination drops ready.

**Pointer update:**
- On `oup_hs`: `rr_q <= (idx_q == N_OUP-1) ? 0 : idx_q + 1`. The wrap uses an explicit compare, not power-of-two truncation.
- When `oup_hs` and `inp_hs` occur in the same cycle, the selection for the new beat uses the updated pointer value `idx_q + 1` (wrapped), computed combinationally.

**Buffer update:**
- `inp_hs`: `full_q <= 1`, `data_q <= inp_data_i`, `idx_q <= sel`.
- Else `oup_hs`: `full_q <= 0`.

**Flush:**
- `flush_i` in cycle t forces `full_q <= 0` and `rr_q <= 0` at the t+1 edge. It overrides both handshake updates.
- An output handshake that completes in cycle t still counts as delivered.
- No input is accepted in cycle t.

**`N_OUP == 1`:** `idx_q` and `rr_q` are constant 0; the block degenerates to a one-entry pipeline register.

## Timing
- **Reset values:**
  - `full_q = 0`, `rr_q = 0`, `idx_q = 0`, `data_q = '0`.
  - Outputs: `oup_valid_o = 0`, `idx_o = 0`, `oup_data_o = '0`, `inp_ready_o = ~flush_i`.
- **Latency:** 1 cycle from input handshake to output valid.
- **Throughput:** 1 beat per cycle, provided each successive destination is ready when its beat is presented.
- **Bypass:** there is no combinational path from input to output. `inp_ready_o` depends combinationally on `oup_ready_i` and `flush_i`.
- **Reset mid-transfer:** reset asserted while a beat is buffered discards the beat immediately (asynchronous). `oup_valid_o` drops in the same cycle as reset assertion.

## Structure
- No package is required. `idx_t` is a local `logic [IdxWidth-1:0]` typedef.
- Sub-module: the existing `lzc` (trailing-zero mode, `WIDTH = N_OUP`) is instantiated once. It runs on the ready vector rotated right by `rr_q`; the result is added back modulo `N_OUP`. The `empty_o` output of `lzc` selects the fallback to `rr_q`.

## Test plan
- **Round-robin with all outputs ready:**
  - Stimulus: `N_OUP = 3`, all `oup_ready_i = 1`, continuous input beats A, B, C, D.
  - Required: outputs 0, 1, 2, 0 in consecutive cycles; `inp_ready_o` stays high.
- **Skip non-ready outputs:**
  - Stimulus: `N_OUP = 4`, `rr_q = 1`, `oup_ready_i = 4'b1001` at capture.
  - Required: beat bound to output 3. After the handshake, `rr_q = 0`.
- **Backpressure stability:**
  - Stimulus: beat 0x5A bound to output 2; `oup_ready_i[2] = 0` for 5 cycles while other readies toggle.
  - Required: `oup_valid_o = 3'b100` and data stay 0x5A throughout; `inp_ready_o = 0`. The beat is delivered on the cycle `oup_ready_i[2]` rises.
- **Flush:**
  - Stimulus: beat buffered for output 1, then `flush_i = 1` for 1 cycle with `inp_valid_i = 1`.
  - Required: `inp_ready_o = 0` in that cycle. Next cycle `oup_valid_o = 0` and `rr_q = 0`; the next accepted beat goes to the first ready output at or after 0.
- **Asynchronous reset mid-stream:**
  - Stimulus: assert `rst_i` between clock edges with a beat buffered.
  - Required: `oup_valid_o = 0` before the next edge; all state is at reset values when `rst_i` deasserts.
- **`N_OUP = 1`:**
  - Stimulus: random valid/ready streams.
  - Required: in-order, lossless delivery with 1-cycle latency; `idx_o = 0` always.
